// File: rtl/div_ctrl.sv
// Programmable clock divider with a handshaked divisor update.
// The active divisor only changes on a period boundary (or in IDLE), so the
// divided clock never shows a truncated or merged period. All visible
// outputs come straight from flops whose next values are decoded from the
// next counter/state values, so each output matches cnt/state in its cycle.
module div_ctrl #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned DIV_RST = 5
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             clk_out,
  output logic             clk_flag,
  output logic             busy,
  output logic             cfg_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] DIV_RST_C = CNT_W'(DIV_RST);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO       = CNT_W'(2);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_act_q, div_act_d;
  logic [CNT_W-1:0] div_pend_q, div_pend_d;

  logic clk_out_q, clk_out_d;
  logic clk_flag_q, clk_flag_d;
  logic busy_q, busy_d;
  logic cfg_err_q, cfg_err_d;
  logic cfg_ready_q, cfg_ready_d;

  logic cfg_xfer;
  logic cfg_legal;
  logic at_boundary;
  logic run_d;

  // Handshake and period-boundary decode.
  assign cfg_xfer    = cfg_valid & cfg_ready_q;
  assign cfg_legal   = (cfg_div >= TWO);
  assign at_boundary = (state_q != IDLE) && (cnt_q == div_act_q - ONE);

  // State register: FSM state, counter, divisors and registered outputs.
  always_ff @(posedge sys_clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    if (sys_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      div_act_q   <= DIV_RST_C;
      div_pend_q  <= DIV_RST_C;
      clk_out_q   <= 1'b0;
      clk_flag_q  <= 1'b0;
      busy_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      cfg_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_act_q   <= div_act_d;
      div_pend_q  <= div_pend_d;
      clk_out_q   <= clk_out_d;
      clk_flag_q  <= clk_flag_d;
      busy_q      <= busy_d;
      cfg_err_q   <= cfg_err_d;
      cfg_ready_q <= cfg_ready_d;
    end
  end

  // Next-state logic: counter advance, divisor hand-over and run/stop decisions.
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_act_d  = div_act_q;
    div_pend_d = div_pend_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (cfg_xfer && cfg_legal) div_act_d = cfg_div;
        if (en) state_d = RUN;
      end
      RUN: begin
        if (at_boundary) begin
          // A divisor offered in the last cycle applies at this very boundary.
          cnt_d = '0;
          if (cfg_xfer && cfg_legal) div_act_d = cfg_div;
          state_d = en ? RUN : IDLE;
        end else begin
          cnt_d = cnt_q + ONE;
          if (cfg_xfer && cfg_legal) begin
            div_pend_d = cfg_div;
            state_d    = PEND;
          end
        end
      end
      PEND: begin
        if (at_boundary) begin
          // The pending divisor is applied even when stopping.
          cnt_d     = '0;
          div_act_d = div_pend_q;
          state_d   = en ? RUN : IDLE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from next-cycle values, so the flops line up with cnt/state.
  always_comb begin
    run_d       = (state_d != IDLE);
    clk_out_d   = run_d && (cnt_d < (div_act_d >> 1));
    clk_flag_d  = run_d && (cnt_d == div_act_d - ONE);
    busy_d      = run_d;
    cfg_err_d   = cfg_xfer && !cfg_legal;
    cfg_ready_d = (state_d != PEND);
  end

  assign cfg_ready = cfg_ready_q;
  assign clk_out   = clk_out_q;
  assign clk_flag  = clk_flag_q;
  assign busy      = busy_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl. Inputs change 1 time unit after a rising edge
// and outputs are sampled at the same point, i.e. they show the cycle that
// the preceding edge started.
module tb_div_ctrl;

  localparam int CNT_W = 8;

  logic             sys_clk = 1'b0;
  logic             sys_rst;
  logic             en;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             clk_out;
  logic             clk_flag;
  logic             busy;
  logic             cfg_err;

  int n_cmp = 0;
  int n_bad = 0;

  div_ctrl #(.CNT_W(CNT_W), .DIV_RST(5)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .en       (en),
    .cfg_valid(cfg_valid),
    .cfg_div  (cfg_div),
    .cfg_ready(cfg_ready),
    .clk_out  (clk_out),
    .clk_flag (clk_flag),
    .busy     (busy),
    .cfg_err  (cfg_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Offer a divisor for exactly one cycle.
  task automatic offer(input logic [CNT_W-1:0] d);
    cfg_valid = 1'b1;
    cfg_div   = d;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    tick(); tick();
    sys_rst = 1'b0;
    n_cmp++; if (clk_out !== 1'b0) begin n_bad++; $display("FAIL reset_clk_out: got %b want 0", clk_out); end
    n_cmp++; if (clk_flag !== 1'b0) begin n_bad++; $display("FAIL reset_clk_flag: got %b want 0", clk_flag); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL reset_cfg_err: got %b want 0", cfg_err); end
    n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL reset_cfg_ready: got %b want 1", cfg_ready); end
  endtask

  // Reset divisor 5: 1,1,0,0,0 with a flag on every 5th cycle.
  task automatic test_div5();
    logic exp_out[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL div5_busy[%0d]: got %b want 1", i, busy); end
      n_cmp++; if (clk_out !== exp_out[i % 5]) begin n_bad++; $display("FAIL div5_clk_out[%0d]: got %b want %b", i, clk_out, exp_out[i % 5]); end
      n_cmp++; if (clk_flag !== (i % 5 == 4)) begin n_bad++; $display("FAIL div5_clk_flag[%0d]: got %b want %b", i, clk_flag, (i % 5 == 4)); end
    end
    en = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL div5_stop_busy: got %b want 0", busy); end
    n_cmp++; if (clk_out !== 1'b0) begin n_bad++; $display("FAIL div5_stop_clk_out: got %b want 0", clk_out); end
  endtask

  // Divisor 4 loaded in IDLE, then run: 1,1,0,0, flag at cnt 3.
  task automatic test_cfg_idle();
    logic exp_out[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL idle_cfg_ready: got %b want 1", cfg_ready); end
    offer(8'd4);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_cfg_busy: got %b want 0", busy); end
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++; if (clk_out !== exp_out[i % 4]) begin n_bad++; $display("FAIL div4_clk_out[%0d]: got %b want %b", i, clk_out, exp_out[i % 4]); end
      n_cmp++; if (clk_flag !== (i % 4 == 3)) begin n_bad++; $display("FAIL div4_clk_flag[%0d]: got %b want %b", i, clk_flag, (i % 4 == 3)); end
    end
    en = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL div4_stop_busy: got %b want 0", busy); end
  endtask

  // Divisor 3 offered at cnt 1 of a period-5 run: PEND for cnt 2..4.
  task automatic test_pend();
    offer(8'd5);
    en = 1'b1;
    tick(); tick();           // cnt 0, cnt 1
    n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL pend_ready_before: got %b want 1", cfg_ready); end
    offer(8'd3);              // now cnt 2
    for (int i = 2; i < 5; i++) begin
      if (i > 2) tick();
      n_cmp++; if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL pend_ready[cnt%0d]: got %b want 0", i, cfg_ready); end
      n_cmp++; if (clk_flag !== (i == 4)) begin n_bad++; $display("FAIL pend_flag[cnt%0d]: got %b want %b", i, clk_flag, (i == 4)); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL pend_busy[cnt%0d]: got %b want 1", i, busy); end
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL div3_ready[%0d]: got %b want 1", i, cfg_ready); end
      n_cmp++; if (clk_out !== (i % 3 == 0)) begin n_bad++; $display("FAIL div3_clk_out[%0d]: got %b want %b", i, clk_out, (i % 3 == 0)); end
      n_cmp++; if (clk_flag !== (i % 3 == 2)) begin n_bad++; $display("FAIL div3_clk_flag[%0d]: got %b want %b", i, clk_flag, (i % 3 == 2)); end
    end
  endtask

  // Divisor offered in the last cycle of a period applies immediately, no PEND.
  task automatic test_boundary_cfg();
    logic exp_out[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    n_cmp++; if (clk_flag !== 1'b1) begin n_bad++; $display("FAIL bnd_pre_flag: got %b want 1", clk_flag); end
    offer(8'd4);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL bnd_ready[%0d]: got %b want 1", i, cfg_ready); end
      n_cmp++; if (clk_out !== exp_out[i]) begin n_bad++; $display("FAIL bnd_clk_out[%0d]: got %b want %b", i, clk_out, exp_out[i]); end
      n_cmp++; if (clk_flag !== (i == 3)) begin n_bad++; $display("FAIL bnd_clk_flag[%0d]: got %b want %b", i, clk_flag, (i == 3)); end
    end
  endtask

  // Illegal divisors in RUN and IDLE: one cfg_err pulse, period unchanged.
  task automatic test_illegal();
    logic [CNT_W-1:0] bad_div[2] = '{8'd1, 8'd0};
    for (int k = 0; k < 2; k++) begin
      offer(bad_div[k]);      // offered at cnt 3 of a period-4 run
      for (int i = 0; i < 4; i++) begin
        if (i > 0) tick();
        n_cmp++; if (cfg_err !== (i == 0)) begin n_bad++; $display("FAIL ill_run%0d_err[%0d]: got %b want %b", k, i, cfg_err, (i == 0)); end
        n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL ill_run%0d_ready[%0d]: got %b want 1", k, i, cfg_ready); end
        n_cmp++; if (clk_flag !== (i == 3)) begin n_bad++; $display("FAIL ill_run%0d_flag[%0d]: got %b want %b", k, i, clk_flag, (i == 3)); end
      end
    end
    en = 1'b0;
    tick();
    offer(8'd1);
    n_cmp++; if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL ill_idle_err: got %b want 1", cfg_err); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ill_idle_busy: got %b want 0", busy); end
    tick();
    n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL ill_idle_err_clear: got %b want 0", cfg_err); end
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (clk_flag !== (i == 3)) begin n_bad++; $display("FAIL ill_idle_period[%0d]: got %b want %b", i, clk_flag, (i == 3)); end
    end
    en = 1'b0;
    tick();
  endtask

  // en dropped at cnt 2 of a period-5 run: period completes, then IDLE.
  task automatic test_en_drop();
    offer(8'd5);
    en = 1'b1;
    tick(); tick(); tick();   // cnt 0, 1, 2
    en = 1'b0;
    tick();                   // cnt 3
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL drop_busy_cnt3: got %b want 1", busy); end
    n_cmp++; if (clk_flag !== 1'b0) begin n_bad++; $display("FAIL drop_flag_cnt3: got %b want 0", clk_flag); end
    tick();                   // cnt 4
    n_cmp++; if (clk_flag !== 1'b1) begin n_bad++; $display("FAIL drop_flag_cnt4: got %b want 1", clk_flag); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL drop_busy_cnt4: got %b want 1", busy); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL drop_idle_busy: got %b want 0", busy); end
    n_cmp++; if (clk_out !== 1'b0) begin n_bad++; $display("FAIL drop_idle_clk_out: got %b want 0", clk_out); end
    n_cmp++; if (clk_flag !== 1'b0) begin n_bad++; $display("FAIL drop_idle_flag: got %b want 0", clk_flag); end
  endtask

  // Reset during PEND discards the pending divisor; restart runs at period 5.
  task automatic test_rst_pend();
    logic exp_out[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    en = 1'b1;
    tick(); tick();           // cnt 0, 1
    offer(8'd3);              // cnt 2, PEND
    n_cmp++; if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL rstp_in_pend: got %b want 0", cfg_ready); end
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL rstp_ready: got %b want 1", cfg_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstp_busy: got %b want 0", busy); end
    n_cmp++; if (clk_out !== 1'b0) begin n_bad++; $display("FAIL rstp_clk_out: got %b want 0", clk_out); end
    n_cmp++; if (clk_flag !== 1'b0) begin n_bad++; $display("FAIL rstp_flag: got %b want 0", clk_flag); end
    n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL rstp_err: got %b want 0", cfg_err); end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++; if (clk_out !== exp_out[i % 5]) begin n_bad++; $display("FAIL rstp_clk_out[%0d]: got %b want %b", i, clk_out, exp_out[i % 5]); end
      n_cmp++; if (clk_flag !== (i % 5 == 4)) begin n_bad++; $display("FAIL rstp_flag[%0d]: got %b want %b", i, clk_flag, (i % 5 == 4)); end
    end
    en = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_div5();
    test_cfg_idle();
    test_pend();
    test_boundary_cfg();
    test_illegal();
    test_en_drop();
    test_rst_pend();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of divisor and period counter.
REQ-002 SHALL have parameter DIV_RST, default 5, active divisor loaded at reset (DIV_RST >= 2).
REQ-003 SHALL have port sys_clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port sys_rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port en  input  1  run request; level-sensitive.
REQ-006 SHALL have port cfg_valid  input  1  new divisor offered.
REQ-007 SHALL have port cfg_div  input  CNT_W  offered divisor, unsigned.
REQ-008 SHALL have port cfg_ready  output  1  divisor can be accepted this cycle.
REQ-009 SHALL have port clk_out  output  1  divided clock.
REQ-010 SHALL have port clk_flag  output  1  one-cycle pulse in last cycle of each period.
REQ-011 SHALL have port busy  output  1  high in RUN or PEND.
REQ-012 SHALL have port cfg_err  output  1  one-cycle pulse after an illegal divisor is consumed.

Function
REQ-013 SHALL implement states IDLE, RUN, PEND, plus registers div_act, div_pend and cnt (CNT_W bits).
REQ-014 A cfg transfer SHALL occur only in a cycle with cfg_valid=1 and cfg_ready=1.
REQ-015 cfg_ready SHALL be 1 in IDLE and RUN, and 0 in PEND.
REQ-016 A transferred cfg_div < 2 SHALL be consumed without state or divisor change, and SHALL raise cfg_err in the next cycle.
REQ-017 A legal transfer in IDLE SHALL load div_act in the next cycle.
REQ-018 A legal transfer in RUN SHALL load div_pend and enter PEND.
REQ-019 Exception to REQ-018: if the transfer cycle is the period's last cycle, the divisor SHALL be applied at that boundary directly and the state SHALL stay RUN.
REQ-020 IDLE -> RUN SHALL occur when en=1 is sampled.
REQ-021 The first RUN cycle SHALL have cnt=0.
REQ-022 In RUN/PEND, cnt SHALL increment each cycle and wrap to 0 after cnt = div_act-1.
REQ-023 At the PEND boundary (cnt = div_act-1), div_act SHALL take div_pend, cnt SHALL restart at 0, and the state SHALL go to RUN; no truncated or merged periods.
REQ-024 clk_out SHALL be 1 when cnt < floor(div_act/2) and 0 otherwise (div 5: 2 high/3 low; div 4: 2/2; div 3: 1/2).
REQ-025 clk_flag SHALL be 1 exactly when cnt = div_act-1.
REQ-026 clk_out, clk_flag, busy and cfg_err SHALL be driven from flops, glitch-free; each value SHALL correspond to cnt/state in that same cycle.
REQ-027 en=0 sampled in RUN/PEND SHALL let the current period complete including clk_flag; at the boundary a pending divisor SHALL still be applied, then the state SHALL go to IDLE.
REQ-028 If en=1 is sampled at that boundary, the block SHALL continue running.
REQ-029 In IDLE: clk_out=0, clk_flag=0, busy=0, cnt=0.
REQ-030 Period-boundary logic SHALL take priority over a same-cycle cfg transfer in PEND; the transfer cannot occur there because cfg_ready=0.
REQ-031 div_act SHALL never hold a value < 2.

Reset
REQ-032 sys_rst=1 at a rising edge SHALL force: state IDLE, cnt=0, div_act=DIV_RST, div_pend=DIV_RST, clk_out=0, clk_flag=0, busy=0, cfg_err=0, cfg_ready=1.
REQ-033 Reset SHALL take priority over all other inputs, including mid-period and in PEND; any pending divisor SHALL be discarded.

Verification
REQ-034 Reset, then en=1 held -> busy=1 next cycle; clk_out pattern 1,1,0,0,0 repeating; clk_flag every 5th cycle of RUN.
REQ-035 In IDLE, cfg_div=4 with cfg_valid=1, then en=1 -> period 4, clk_out 1,1,0,0, clk_flag when cnt=3.
REQ-036 Running at div 5, cfg_div=3 offered at cnt=1 -> cfg_ready=0 for the next 3 cycles (PEND); clk_flag at cnt=4; then period 3, clk_out 1,0,0.
REQ-037 cfg_div=1 or 0 offered (IDLE and RUN) -> cfg_err pulses once; period unchanged; cfg_ready stays 1.
REQ-038 Running at div 5, en dropped at cnt=2 -> cnt 3,4 continue, clk_flag at cnt=4, then IDLE, clk_out=0, busy=0.
REQ-039 sys_rst asserted during PEND -> next cycle all outputs at reset values; restart with en=1 gives a period-5 waveform.
